// File: rtl/csr_bram_loader.sv
// csr_bram_loader
//   Packs a 32-bit valid/ready word stream into 512-bit CSR lines and writes
//   them to consecutive addresses of the CSR block RAM, starting at address 0.
//   It pulses done once the whole table is resident, so traversal can be
//   released only after that point.
// Ports
//   clk, reset      single clock; synchronous active-high reset
//   start           1-cycle pulse that begins a load of num_lines lines
//   num_lines       line count, sampled only on an accepted start
//   in_valid/in_ready/in_data   input word stream (word 0 -> bits [31:0])
//   bram_en/bram_we/bram_addr/bram_din   BRAM write port
//   busy            load in progress
//   done            1-cycle completion pulse
//   lines_written   lines committed since the last accepted start
//   cfg_err         sticky: invalid num_lines, or start while busy
module csr_bram_loader #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 512,
  parameter int IN_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_lines,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   lines_written,
  output logic              cfg_err
);

  localparam int WPL   = DATA_W / IN_W;
  localparam int CNT_W = $clog2(WPL);

  localparam logic [ADDR_W:0]   MAX_LINES = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_LINE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WPL - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [ADDR_W:0]   n_lines;
  logic [ADDR_W-1:0] line_idx;
  logic [CNT_W-1:0]  word_cnt;
  logic [DATA_W-1:0] line_buf;
  logic [DATA_W-1:0] line_next;

  logic beat;
  logic start_ok;
  logic last_word;
  logic last_line;

  assign beat      = in_valid & in_ready;
  assign start_ok  = start && (num_lines != '0) && (num_lines <= MAX_LINES);
  assign last_word = (word_cnt == LAST_WORD);
  assign last_line = ((ADDR_W + 1)'(line_idx) + ONE_LINE) == n_lines;

  // Line buffer with the current beat merged in; on the final beat this is
  // the complete line and goes straight into bram_din.
  always_comb begin
    line_next = line_buf;
    line_next[word_cnt * IN_W +: IN_W] = in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start_ok) next_state = S_FILL;
      S_FILL:  if (beat && last_word) next_state = S_WRITE;
      S_WRITE: next_state = last_line ? S_DONE : S_FILL;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  assign bram_en = (state == S_WRITE);
  assign bram_we = (state == S_WRITE);
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready      <= 1'b0;
      n_lines       <= '0;
      line_idx      <= '0;
      word_cnt      <= '0;
      line_buf      <= '0;
      bram_addr     <= '0;
      bram_din      <= '0;
      lines_written <= '0;
      cfg_err       <= 1'b0;
    end else begin
      // Registered ready: high exactly while the FSM sits in FILL.
      in_ready <= (next_state == S_FILL);

      case (state)
        S_IDLE: begin
          if (start) begin
            if (start_ok) begin
              n_lines       <= num_lines;
              line_idx      <= '0;
              word_cnt      <= '0;
              lines_written <= '0;
              cfg_err       <= 1'b0;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (beat) begin
            line_buf <= line_next;
            word_cnt <= word_cnt + CNT_W'(1);
            if (last_word) begin
              bram_addr <= line_idx;
              bram_din  <= line_next;
            end
          end
        end
        S_WRITE: begin
          lines_written <= lines_written + ONE_LINE;
          if (!last_line) line_idx <= line_idx + ADDR_W'(1);
        end
        default: ;
      endcase

      if (start && (state != S_IDLE)) cfg_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_csr_bram_loader.sv
// tb_csr_bram_loader
//   Directed bench for csr_bram_loader. Expected BRAM writes are queued when a
//   load is issued; a monitor pops and compares them whenever the write port
//   fires, and mirrors committed lines into a behavioural BRAM for read-back.
module tb_csr_bram_loader;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 512;
  localparam int IN_W   = 32;

  localparam logic [DATA_W-1:0] LINE_T1 = {
    32'h0000000f, 32'h0000000e, 32'h0000000d, 32'h0000000c,
    32'h0000000b, 32'h0000000a, 32'h00000009, 32'h00000008,
    32'h00000007, 32'h00000006, 32'h00000005, 32'h00000004,
    32'h00000003, 32'h00000002, 32'h00000001, 32'h00000000};

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   num_lines;
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_data;
  logic              bram_en;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   lines_written;
  logic              cfg_err;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  bit prev_we     = 1'b0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               exp_q[$];
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

  csr_bram_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IN_W(IN_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .num_lines     (num_lines),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .bram_en       (bram_en),
    .bram_we       (bram_we),
    .bram_addr     (bram_addr),
    .bram_din      (bram_din),
    .busy          (busy),
    .done          (done),
    .lines_written (lines_written),
    .cfg_err       (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk_line(input logic [31:0] base);
    logic [DATA_W-1:0] l;
    l = '0;
    for (int k = 0; k < DATA_W / IN_W; k++) l[k*IN_W +: IN_W] = base + 32'(k);
    return l;
  endfunction

  task automatic push_lines(input logic [31:0] base, input int n);
    wr_t e;
    for (int l = 0; l < n; l++) begin
      e.addr = ADDR_W'(l);
      e.data = mk_line(base + 32'(16 * l));
      exp_q.push_back(e);
    end
  endtask

  // Monitor: runs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    wr_t e;
    if (bram_en || bram_we) begin
      chk("we_matches_en", DATA_W'(bram_we), DATA_W'(bram_en));
      chk("in_ready_low_on_write", DATA_W'(in_ready), '0);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addr %0h, no write expected", bram_addr);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", DATA_W'(bram_addr), DATA_W'(e.addr));
        chk("write_data", bram_din, e.data);
      end
      mem[bram_addr] = bram_din;
    end
    if (done === 1'b1) begin
      done_cnt++;
      chk("done_one_cycle_after_write", DATA_W'(prev_we), DATA_W'(1));
    end
    prev_we = (bram_we === 1'b1);
  end

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic pulse_start(input logic [ADDR_W:0] n);
    start = 1'b1; num_lines = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_words(input logic [31:0] base, input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      int t;
      bit acc;
      t = 0; acc = 1'b0;
      in_valid = 1'b1;
      in_data  = base + 32'(i);
      while (!acc && t < 200) begin
        @(negedge clk);
        acc = (in_ready === 1'b1);
        @(posedge clk); #1;
        t++;
      end
      in_valid = 1'b0;
      if (!acc) begin
        vectors++;
        miscompares++;
        $display("FAIL word_accept_timeout: word %0d not accepted, in_ready %b", i, in_ready);
        return;
      end
      if (toggle) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (done !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(name, DATA_W'(done), DATA_W'(1));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"},      DATA_W'(in_ready), '0);
    chk({tag, "_bram_en"},       DATA_W'(bram_en), '0);
    chk({tag, "_bram_we"},       DATA_W'(bram_we), '0);
    chk({tag, "_busy"},          DATA_W'(busy), '0);
    chk({tag, "_done"},          DATA_W'(done), '0);
    chk({tag, "_cfg_err"},       DATA_W'(cfg_err), '0);
    chk({tag, "_bram_addr"},     DATA_W'(bram_addr), '0);
    chk({tag, "_bram_din"},      bram_din, '0);
    chk({tag, "_lines_written"}, DATA_W'(lines_written), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    wr_t e;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; num_lines = '0; in_data = '0;

    // Reset values.
    do_reset();
    @(negedge clk);
    check_reset_vals("reset");

    // 1: single line, back-to-back words 0..15.
    @(posedge clk); #1;
    e.addr = '0; e.data = LINE_T1;
    exp_q.push_back(e);
    d0 = done_cnt;
    pulse_start(18'd1);
    send_words(32'h0, 16, 1'b0);
    wait_done("t1_done");
    chk("t1_lines_written", DATA_W'(lines_written), DATA_W'(1));
    @(negedge clk);
    chk("t1_done_single_cycle", DATA_W'(done), '0);
    chk("t1_busy_cleared", DATA_W'(busy), '0);
    chk("t1_done_count", DATA_W'(done_cnt - d0), DATA_W'(1));

    // 2: three lines with in_valid toggling.
    @(posedge clk); #1;
    push_lines(32'h0, 3);
    d0 = done_cnt;
    pulse_start(18'd3);
    send_words(32'h0, 48, 1'b1);
    wait_done("t2_done");
    chk("t2_lines_written", DATA_W'(lines_written), DATA_W'(3));
    @(negedge clk);
    chk("t2_done_count", DATA_W'(done_cnt - d0), DATA_W'(1));

    // 3: invalid counts, plus the 2**ADDR_W upper bound being accepted.
    do_reset();
    d0 = done_cnt;
    pulse_start(18'h20001);
    @(negedge clk);
    chk("t3_over_cfg_err", DATA_W'(cfg_err), DATA_W'(1));
    chk("t3_over_busy", DATA_W'(busy), '0);
    @(posedge clk); #1;
    pulse_start(18'h20000);
    @(negedge clk);
    chk("t3_max_busy", DATA_W'(busy), DATA_W'(1));
    chk("t3_max_cfg_err_cleared", DATA_W'(cfg_err), '0);
    chk("t3_max_in_ready", DATA_W'(in_ready), DATA_W'(1));
    do_reset();
    pulse_start(18'd0);
    @(negedge clk);
    chk("t3_zero_cfg_err", DATA_W'(cfg_err), DATA_W'(1));
    chk("t3_zero_busy", DATA_W'(busy), '0);
    repeat (3) @(negedge clk);
    chk("t3_no_done", DATA_W'(done_cnt - d0), '0);

    // 4: start during FILL is flagged but does not disturb the load.
    @(posedge clk); #1;
    push_lines(32'h4000_0000, 2);
    d0 = done_cnt;
    pulse_start(18'd2);
    @(negedge clk);
    chk("t4_cfg_err_cleared", DATA_W'(cfg_err), '0);
    @(posedge clk); #1;
    send_words(32'h4000_0000, 8, 1'b0);
    pulse_start(18'd5);
    @(negedge clk);
    chk("t4_cfg_err_set", DATA_W'(cfg_err), DATA_W'(1));
    chk("t4_still_busy", DATA_W'(busy), DATA_W'(1));
    @(posedge clk); #1;
    send_words(32'h4000_0008, 24, 1'b0);
    wait_done("t4_done");
    chk("t4_lines_written", DATA_W'(lines_written), DATA_W'(2));
    repeat (3) @(negedge clk);
    chk("t4_done_once", DATA_W'(done_cnt - d0), DATA_W'(1));
    chk("t4_cfg_err_sticky", DATA_W'(cfg_err), DATA_W'(1));

    // 5: reset in the middle of line 1 discards the partial line.
    mem.delete();
    @(posedge clk); #1;
    push_lines(32'hA000_0000, 1);
    pulse_start(18'd2);
    send_words(32'hA000_0000, 24, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_vals("t5");
    #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("t5_addr0_written", DATA_W'(mem.exists(0)), DATA_W'(1));
    chk("t5_addr1_not_written", DATA_W'(mem.exists(1)), '0);
    chk("t5_busy_idle", DATA_W'(busy), '0);

    // start on the same edge as reset: reset wins.
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b1; num_lines = 18'd1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", DATA_W'(busy), '0);
    chk("rst_start_in_ready", DATA_W'(in_ready), '0);

    // 6: four lines, then read the table back.
    mem.delete();
    @(posedge clk); #1;
    push_lines(32'h7700_0100, 4);
    pulse_start(18'd4);
    send_words(32'h7700_0100, 64, 1'b0);
    wait_done("t6_done");
    chk("t6_lines_written", DATA_W'(lines_written), DATA_W'(4));
    for (int l = 0; l < 4; l++) begin
      logic [ADDR_W-1:0] a;
      a = ADDR_W'(l);
      chk("t6_line_present", DATA_W'(mem.exists(a)), DATA_W'(1));
      if (mem.exists(a))
        chk("t6_readback", mem[a], mk_line(32'h7700_0100 + 32'(16 * l)));
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", DATA_W'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
